// File: rtl/lenet_weight_loader_if.sv
`timescale 1ns/1ps
// Stream and buffer-write bundle of the LeNet weight loader: host byte stream in,
// weight buffer and bias buffer write ports out.
interface lenet_weight_loader_if #(
   parameter int DATA_W  = 8,
   parameter int WADDR_W = 12,
   parameter int BADDR_W = 5,
   parameter int BIAS_W  = 32
);
   logic                     s_wt_valid_i;
   logic [DATA_W-1:0]        s_wt_data_i;
   logic                     s_wt_ready_o;
   logic                     wbuf_we_o;
   logic [WADDR_W-1:0]       wbuf_addr_o;
   logic [DATA_W-1:0]        wbuf_wdata_o;
   logic                     bias_we_o;
   logic [BADDR_W-1:0]       bias_addr_o;
   logic signed [BIAS_W-1:0] bias_wdata_o;

   modport master (
      input  s_wt_valid_i, s_wt_data_i,
      output s_wt_ready_o,
      output wbuf_we_o, wbuf_addr_o, wbuf_wdata_o,
      output bias_we_o, bias_addr_o, bias_wdata_o
   );

   modport slave (
      output s_wt_valid_i, s_wt_data_i,
      input  s_wt_ready_o,
      input  wbuf_we_o, wbuf_addr_o, wbuf_wdata_o,
      input  bias_we_o, bias_addr_o, bias_wdata_o
   );
endinterface

// File: rtl/lenet_weight_loader.sv
`timescale 1ns/1ps
// LeNet-5 weight/bias loader: fetches a layer's parameter byte stream from the host,
// writes weights to the systolic weight buffer and packed 32-bit biases to the bias buffer.
module lenet_weight_loader #(
   parameter int DATA_W  = 8,
   parameter int WADDR_W = 12,
   parameter int BADDR_W = 5,
   parameter int BIAS_W  = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_async_i,
   input  logic                 req_load_weight_i,
   input  logic [3:0]           layer_id_i,
   output logic                 weight_loaded_o,
   output logic                 err_o,
   output logic                 fetch_req_o,
   output logic [3:0]           fetch_layer_o,
   lenet_weight_loader_if.master wt
);
   localparam int ASM_W  = BIAS_W - DATA_W;
   localparam int BSEL_W = $clog2(BIAS_W / DATA_W);
   localparam logic [BSEL_W-1:0] BYTE_LAST = BSEL_W'(BIAS_W / DATA_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_LOAD_W, ST_LOAD_B, ST_FLUSH, ST_DONE, ST_ERR, ST_WAIT_DROP
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         layer_q;
   logic [WADDR_W-1:0] wcnt_q;
   logic [BADDR_W-1:0] bword_q;
   logic [BSEL_W-1:0]  bbyte_q;
   logic [ASM_W-1:0]   asm_q;
   logic               beat, last_w, last_b, accept_ok;

   function automatic logic id_ok(input logic [3:0] id);
      return (id == 4'd1) || (id == 4'd2);
   endfunction

   function automatic logic [WADDR_W-1:0] w_last(input logic [3:0] id);
      case (id)
         4'd1:    return WADDR_W'(149);
         4'd2:    return WADDR_W'(2399);
         default: return '0;
      endcase
   endfunction

   function automatic logic [BADDR_W-1:0] b_last(input logic [3:0] id);
      case (id)
         4'd1:    return BADDR_W'(5);
         4'd2:    return BADDR_W'(15);
         default: return '0;
      endcase
   endfunction

   assign beat      = wt.s_wt_valid_i & wt.s_wt_ready_o;
   assign last_w    = beat && (wcnt_q == w_last(layer_q));
   assign last_b    = beat && (bbyte_q == BYTE_LAST) && (bword_q == b_last(layer_q));
   assign accept_ok = (state_q == ST_IDLE) && req_load_weight_i && id_ok(layer_id_i);

   always_ff @(posedge clk_i or posedge rst_async_i) begin
      if (rst_async_i) state_q <= ST_IDLE;
      else             state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (req_load_weight_i) state_d = id_ok(layer_id_i) ? ST_LOAD_W : ST_ERR;
         ST_LOAD_W:    if (last_w) state_d = ST_LOAD_B;
         ST_LOAD_B:    if (last_b) state_d = ST_FLUSH;
         ST_FLUSH:     state_d = ST_DONE;
         ST_DONE:      state_d = ST_WAIT_DROP;
         ST_ERR:       state_d = ST_WAIT_DROP;
         ST_WAIT_DROP: if (!req_load_weight_i) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // Completion pulse is launched from FLUSH so the last bias write lands one cycle earlier.
   always_ff @(posedge clk_i or posedge rst_async_i) begin
      if (rst_async_i) begin
         weight_loaded_o  <= 1'b0;
         err_o            <= 1'b0;
         fetch_req_o      <= 1'b0;
         fetch_layer_o    <= '0;
         layer_q          <= '0;
         wcnt_q           <= '0;
         bword_q          <= '0;
         bbyte_q          <= '0;
         asm_q            <= '0;
         wt.s_wt_ready_o  <= 1'b0;
         wt.wbuf_we_o     <= 1'b0;
         wt.wbuf_addr_o   <= '0;
         wt.wbuf_wdata_o  <= '0;
         wt.bias_we_o     <= 1'b0;
         wt.bias_addr_o   <= '0;
         wt.bias_wdata_o  <= '0;
      end else begin
         fetch_req_o     <= accept_ok;
         weight_loaded_o <= (state_q == ST_FLUSH) || (state_q == ST_ERR);
         err_o           <= err_o | (state_q == ST_ERR);
         wt.s_wt_ready_o <= (state_d == ST_LOAD_W) || (state_d == ST_LOAD_B);
         wt.wbuf_we_o    <= (state_q == ST_LOAD_W) && beat;
         wt.bias_we_o    <= (state_q == ST_LOAD_B) && beat && (bbyte_q == BYTE_LAST);

         if (accept_ok)                fetch_layer_o <= layer_id_i;
         else if (state_q == ST_DONE)  fetch_layer_o <= '0;

         if (state_q == ST_IDLE) begin
            wcnt_q  <= '0;
            bword_q <= '0;
            bbyte_q <= '0;
            asm_q   <= '0;
            if (req_load_weight_i) layer_q <= layer_id_i;
         end

         if ((state_q == ST_LOAD_W) && beat) begin
            wt.wbuf_addr_o  <= wcnt_q;
            wt.wbuf_wdata_o <= wt.s_wt_data_i;
            wcnt_q          <= wcnt_q + WADDR_W'(1);
         end

         // Bytes arrive LSB first; the assembler holds the three most recent ones.
         if ((state_q == ST_LOAD_B) && beat) begin
            asm_q   <= {wt.s_wt_data_i, asm_q[ASM_W-1:DATA_W]};
            bbyte_q <= bbyte_q + BSEL_W'(1);
            if (bbyte_q == BYTE_LAST) begin
               wt.bias_addr_o  <= bword_q;
               wt.bias_wdata_o <= $signed({wt.s_wt_data_i, asm_q});
               bword_q         <= bword_q + BADDR_W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_lenet_weight_loader.sv
`timescale 1ns/1ps
// Scoreboard bench for lenet_weight_loader: randomized byte streams, expected writes
// derived from the layer table and little-endian bias packing.
module tb_lenet_weight_loader;
   localparam int DATA_W = 8, WADDR_W = 12, BADDR_W = 5, BIAS_W = 32;

   logic       clk = 1'b0;
   logic       rst, req;
   logic [3:0] layer_id;
   logic       loaded, err, fetch_req;
   logic [3:0] fetch_layer;

   lenet_weight_loader_if #(.DATA_W(DATA_W), .WADDR_W(WADDR_W), .BADDR_W(BADDR_W), .BIAS_W(BIAS_W)) wt ();

   lenet_weight_loader #(.DATA_W(DATA_W), .WADDR_W(WADDR_W), .BADDR_W(BADDR_W), .BIAS_W(BIAS_W)) dut (
      .clk_i(clk), .rst_async_i(rst), .req_load_weight_i(req), .layer_id_i(layer_id),
      .weight_loaded_o(loaded), .err_o(err), .fetch_req_o(fetch_req), .fetch_layer_o(fetch_layer),
      .wt(wt)
   );

   always #5 clk = ~clk;

   typedef struct { int addr; longint data; time t; } wr_t;
   typedef struct { string name; longint act; longint exp; } chk_t;

   wr_t        wq[$];
   wr_t        bq[$];
   time        lq[$];
   chk_t       cq[$];
   logic [7:0] stream[$];
   int         n_chk = 0, n_pass = 0, fetch_cnt = 0, n_fetch_exp = 0;

   function automatic int n_w(input int id);
      return (id == 1) ? 150 : ((id == 2) ? 2400 : 0);
   endfunction

   function automatic int n_b(input int id);
      return (id == 1) ? 6 : ((id == 2) ? 16 : 0);
   endfunction

   function void post(input string n, input longint a, input longint e);
      cq.push_back('{n, a, e});
   endfunction

   // Monitor: all comparisons are counted here.
   always @(negedge clk) begin : mon
      chk_t c;
      wr_t  e;
      time  et;
      while (cq.size() != 0) begin
         c = cq.pop_front();
         n_chk++;
         if (c.act == c.exp) n_pass++;
         else $display("FAIL %s: got %0d, expected %0d", c.name, c.act, c.exp);
      end
      if (!rst) begin
         if (fetch_req) fetch_cnt++;
         if (wt.wbuf_we_o) begin
            n_chk++;
            if (wq.size() == 0)
               $display("FAIL wbuf_write: unexpected write addr %0d data %0d at %0t",
                        wt.wbuf_addr_o, wt.wbuf_wdata_o, $time);
            else begin
               e = wq.pop_front();
               if (int'(wt.wbuf_addr_o) == e.addr && longint'(wt.wbuf_wdata_o) == e.data && $time == e.t)
                  n_pass++;
               else
                  $display("FAIL wbuf_write: got addr %0d data %0d at %0t, expected addr %0d data %0d at %0t",
                           wt.wbuf_addr_o, wt.wbuf_wdata_o, $time, e.addr, e.data, e.t);
            end
         end
         if (wt.bias_we_o) begin
            n_chk++;
            if (bq.size() == 0)
               $display("FAIL bias_write: unexpected write addr %0d data %0d at %0t",
                        wt.bias_addr_o, wt.bias_wdata_o, $time);
            else begin
               e = bq.pop_front();
               if (int'(wt.bias_addr_o) == e.addr && longint'(wt.bias_wdata_o) == e.data && $time == e.t)
                  n_pass++;
               else
                  $display("FAIL bias_write: got addr %0d data %0d at %0t, expected addr %0d data %0d at %0t",
                           wt.bias_addr_o, wt.bias_wdata_o, $time, e.addr, e.data, e.t);
            end
         end
         if (loaded) begin
            n_chk++;
            if (lq.size() == 0) $display("FAIL weight_loaded: unexpected pulse at %0t", $time);
            else begin
               et = lq.pop_front();
               if ($time == et) n_pass++;
               else $display("FAIL weight_loaded: pulse at %0t, expected at %0t", $time, et);
            end
         end
      end
   end

   // Stream image: weights then biases, little-endian bytes.
   task automatic build(input int id, input int mode);
      logic [7:0] pat [8];
      pat = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      stream.delete();
      for (int i = 0; i < n_w(id); i++) stream.push_back(mode == 0 ? 8'(i) : 8'($urandom));
      for (int k = 0; k < n_b(id); k++)
         for (int b = 0; b < 4; b++) begin
            if (mode == 0)               stream.push_back(b == 0 ? 8'(k + 1) : 8'h00);
            else if (mode == 1 && k < 2) stream.push_back(pat[4*k + b]);
            else                         stream.push_back(8'($urandom));
         end
   endtask

   // Called at posedge+1; returns at posedge+1 after the request has been taken.
   task automatic start_req(input logic [3:0] id, input bit hold);
      bit ok;
      ok = (n_w(int'(id)) != 0);
      req = 1'b1;
      layer_id = id;
      @(posedge clk);
      if (!ok) lq.push_back($time + 15);
      #1;
      layer_id = 4'($urandom);
      if (ok) begin
         n_fetch_exp++;
         post("fetch_req_pulse", longint'(fetch_req), 1);
         post("ready_after_req", longint'(wt.s_wt_ready_o), 1);
         post("fetch_layer", longint'(fetch_layer), longint'(id));
      end else begin
         post("bad_id_no_fetch", longint'(fetch_req), 0);
         post("bad_id_no_ready", longint'(wt.s_wt_ready_o), 0);
      end
      if (!hold) req = 1'b0;
   endtask

   task automatic send(input int id, input int gap_pct, input int stop_after);
      int     nw, tot, i, j, base, guard;
      bit     acc;
      longint v;
      nw = n_w(id);
      tot = nw + 4 * n_b(id);
      i = 0;
      guard = 0;
      while (i < tot && i < stop_after && guard < 20000) begin
         if (int'($urandom_range(99)) < gap_pct) begin
            wt.s_wt_valid_i = 1'b0;
            wt.s_wt_data_i  = 8'($urandom);
         end else begin
            wt.s_wt_valid_i = 1'b1;
            wt.s_wt_data_i  = stream[i];
         end
         acc = wt.s_wt_valid_i && wt.s_wt_ready_o;
         @(posedge clk);
         if (acc) begin
            if (i < nw) wq.push_back('{i, longint'(stream[i]), $time + 5});
            else begin
               j = i - nw;
               if (j % 4 == 3) begin
                  base = nw + j - 3;
                  v = longint'(stream[base]) + 256 * longint'(stream[base+1])
                    + 65536 * longint'(stream[base+2]) + 16777216 * longint'(stream[base+3]);
                  if (v >= 64'sd2147483648) v = v - 64'sd4294967296;
                  bq.push_back('{j / 4, v, $time + 5});
               end
            end
            if (i == tot - 1) lq.push_back($time + 15);
            i++;
         end
         #1;
         guard++;
      end
      wt.s_wt_valid_i = 1'b0;
      if (guard >= 20000) post("stream_timeout", i, tot);
   endtask

   task automatic wait_done();
      int g;
      g = 0;
      while (lq.size() != 0 && g < 40) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (g >= 40) post("loaded_timeout", lq.size(), 0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int bad, f0;
      rst = 1'b1;
      req = 1'b0;
      layer_id = '0;
      wt.s_wt_valid_i = 1'b0;
      wt.s_wt_data_i  = '0;
      idle(2);
      post("rst_loaded", longint'(loaded), 0);
      post("rst_err", longint'(err), 0);
      post("rst_fetch_req", longint'(fetch_req), 0);
      post("rst_ready", longint'(wt.s_wt_ready_o), 0);
      post("rst_we", longint'({wt.wbuf_we_o, wt.bias_we_o}), 0);
      rst = 1'b0;
      idle(1);

      // Counting layer 1, request held high well past completion.
      build(1, 0);
      start_req(4'd1, 1'b1);
      send(1, 0, 1 << 30);
      wait_done();
      f0 = fetch_cnt;
      bad = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (wt.s_wt_ready_o || fetch_req) bad++;
      end
      post("hold_no_retrigger", bad, 0);
      post("hold_fetch_count", fetch_cnt, f0);
      req = 1'b0;
      idle(2);

      // Bias packing pattern, then layer 2 with valid gaps.
      build(1, 1);
      start_req(4'd1, 1'b0);
      send(1, 0, 1 << 30);
      wait_done();
      idle(2);
      build(2, 2);
      start_req(4'd2, 1'b0);
      send(2, 30, 1 << 30);
      wait_done();
      idle(2);

      // Unsupported layer with stray stream beats.
      f0 = fetch_cnt;
      start_req(4'd3, 1'b0);
      wt.s_wt_valid_i = 1'b1;
      wt.s_wt_data_i  = 8'hA5;
      bad = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (wt.s_wt_ready_o) bad++;
      end
      wt.s_wt_valid_i = 1'b0;
      post("bad_id_ready_low", bad, 0);
      wait_done();
      post("err_set", longint'(err), 1);
      post("bad_id_fetch_count", fetch_cnt, f0);
      idle(2);

      build(1, 2);
      start_req(4'd1, 1'b0);
      send(1, 20, 1 << 30);
      wait_done();
      post("err_sticky", longint'(err), 1);
      idle(2);

      // Abort after 80 weight beats.
      build(1, 2);
      start_req(4'd1, 1'b0);
      send(1, 0, 80);
      rst = 1'b1;
      wq.delete();
      bq.delete();
      lq.delete();
      #2;
      post("rst_mid_ctrl", longint'({loaded, err, fetch_req, wt.s_wt_ready_o, wt.wbuf_we_o,
                                      wt.bias_we_o, fetch_layer, wt.wbuf_addr_o, wt.wbuf_wdata_o,
                                      wt.bias_addr_o}), 0);
      post("rst_mid_bias_data", longint'(wt.bias_wdata_o), 0);
      idle(2);
      rst = 1'b0;
      idle(2);
      build(1, 2);
      start_req(4'd1, 1'b0);
      send(1, 25, 1 << 30);
      wait_done();
      post("err_cleared", longint'(err), 0);
      idle(3);

      post("wbuf_drained", wq.size(), 0);
      post("bias_drained", bq.size(), 0);
      post("loaded_drained", lq.size(), 0);
      post("fetch_total", fetch_cnt, n_fetch_exp);
      idle(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
